// File: rtl/vga_reg_writer_pkg.sv
// Shared constants and FSM encoding for vga_reg_writer and its BCD inversion helper.
package vga_reg_writer_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int TMO_W  = 4;

  localparam logic [ADDR_W-1:0] ADDR_40 = 8'd40;
  localparam logic [ADDR_W-1:0] ADDR_41 = 8'd41;
  localparam logic [ADDR_W-1:0] ADDR_42 = 8'd42;
  localparam logic [ADDR_W-1:0] ADDR_43 = 8'd43;
  localparam logic [ADDR_W-1:0] ADDR_44 = 8'd44;
  localparam logic [ADDR_W-1:0] ADDR_45 = 8'd45;
  localparam logic [ADDR_W-1:0] ADDR_46 = 8'd46;
  localparam logic [ADDR_W-1:0] ADDR_47 = 8'd47;
  localparam logic [ADDR_W-1:0] ADDR_48 = 8'd48;
  localparam logic [ADDR_W-1:0] ADDR_49 = 8'd49;
  localparam logic [ADDR_W-1:0] ADDR_50 = 8'd50;
  localparam logic [ADDR_W-1:0] ADDR_51 = 8'd51;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_WRITE    = 3'd3,
    ST_NEXT     = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // Registers 50 and 51 hold single flag bits; only bit 0 is meaningful.
  function automatic logic is_bit_addr(input logic [ADDR_W-1:0] addr);
    return (addr == ADDR_50) || (addr == ADDR_51);
  endfunction

endpackage

// File: rtl/vga_reg_writer_crono_bcd_invert.sv
// crono_bcd_invert: combinational BCD count-down conversion for registers 46-48.
// Only compiled when CRONO_INVERT_EN is defined.
`ifdef CRONO_INVERT_EN
module crono_bcd_invert
  import vga_reg_writer_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [3:0] tens;
  logic [3:0] units;

  assign tens  = din[7:4];
  assign units = din[3:0];

  // 46/47 count down within a 0..59 field; 48 within a 0..23 field.
  always_comb begin
    dout = din;
    if ((addr == ADDR_46) || (addr == ADDR_47)) begin
      dout = {4'd5 - tens, 4'd9 - units};
    end else if (addr == ADDR_48) begin
      if (units > 4'd3) begin
        dout = {4'd1 - tens, 4'd13 - units};
      end else begin
        dout = {4'd2 - tens, 4'd3 - units};
      end
    end
  end

endmodule
`endif

// File: rtl/vga_reg_writer.sv
// vga_reg_writer: on each VSync falling edge, copies source registers ADDR_FIRST..ADDR_LAST
// (skipping ADDR_SKIP) into the display register bank. Define CRONO_INVERT_EN for BCD inversion.
module vga_reg_writer
  import vga_reg_writer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_FIRST  = ADDR_40,
  parameter logic [ADDR_W-1:0] ADDR_LAST   = ADDR_51,
  parameter logic [ADDR_W-1:0] ADDR_SKIP   = ADDR_43,
  parameter logic [TMO_W-1:0]  ACK_TIMEOUT = 4'd15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VSync,
  output logic [ADDR_W-1:0] SrcAddr,
  output logic              SrcReq,
  input  logic              SrcAck,
  input  logic [DATA_W-1:0] SrcData,
  output logic [ADDR_W-1:0] MemAddrOUT,
  output logic [DATA_W-1:0] MemDataOUT,
  output logic              Write,
  output logic              Busy,
  output logic              FrameDone,
  output logic              SrcErr,
  output state_e            dbg_state
);

  localparam logic [TMO_W-1:0] TMO_LAST = ACK_TIMEOUT - 1'b1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              vsync_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              err_q, err_d;

  logic              vsync_fall;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_step;
  logic [DATA_W-1:0] conv_data;
  logic [DATA_W-1:0] wr_data;

`ifdef CRONO_INVERT_EN
  crono_bcd_invert u_crono_bcd_invert (
    .addr (addr_q),
    .din  (SrcData),
    .dout (conv_data)
  );
`else
  assign conv_data = SrcData;
`endif

  assign wr_data    = is_bit_addr(addr_q) ? {7'd0, SrcData[0]} : conv_data;
  assign vsync_fall = vsync_q & ~VSync;
  assign addr_inc   = addr_q + 8'd1;
  assign addr_step  = (addr_inc == ADDR_SKIP) ? addr_inc + 8'd1 : addr_inc;

  // Handshake: SrcReq is held high through REQ and WAIT_ACK; a cycle in WAIT_ACK
  // with SrcAck=1 transfers SrcData in that same cycle and SrcReq drops next cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tmo_d      = tmo_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (vsync_fall) begin
          state_d = ST_REQ;
          addr_d  = ADDR_FIRST;
          tmo_d   = '0;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (SrcAck) begin
          mem_addr_d = addr_q;
          mem_data_d = wr_data;
          state_d    = ST_WRITE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_NEXT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WRITE: begin
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (addr_q == ADDR_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_REQ;
          addr_d  = addr_step;
          tmo_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Leaving the blanking window mid-sweep abandons the frame without side effects.
    if ((state_q != ST_IDLE) && VSync) begin
      state_d    = ST_IDLE;
      addr_d     = addr_q;
      tmo_d      = tmo_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      err_d      = err_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      tmo_q      <= '0;
      vsync_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tmo_q      <= tmo_d;
      vsync_q    <= VSync;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      err_q      <= err_d;
    end
  end

  assign SrcAddr    = addr_q;
  assign SrcReq     = (state_q == ST_REQ) || (state_q == ST_WAIT_ACK);
  assign MemAddrOUT = mem_addr_q;
  assign MemDataOUT = mem_data_q;
  assign Write      = (state_q == ST_WRITE);
  assign Busy       = (state_q != ST_IDLE);
  assign FrameDone  = (state_q == ST_DONE);
  assign SrcErr     = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_vga_reg_writer.sv
// Directed/randomized bench for vga_reg_writer with a source model and a write scoreboard.
module tb_vga_reg_writer;
  import vga_reg_writer_pkg::*;

  logic       CLK;
  logic       RESET;
  logic       VSync;
  logic [7:0] SrcAddr;
  logic       SrcReq;
  logic       SrcAck;
  logic [7:0] SrcData;
  logic [7:0] MemAddrOUT;
  logic [7:0] MemDataOUT;
  logic       Write;
  logic       Busy;
  logic       FrameDone;
  logic       SrcErr;
  state_e     dbg_state;

  int total = 0;
  int bad   = 0;

  logic [7:0]  src_mem [256];
  bit          no_ack [256];
  int          ack_dly [256];
  int          req_cnt = 0;
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];
  logic [7:0]  req_q [$];
  int          req_cycles [256];
  int          fd_cnt = 0;
  int          err_at = -1;
  int          wr_double = 0;
  int          hold_err = 0;
  logic        req_prev = 1'b0;
  logic        err_prev = 1'b0;
  logic        wr_prev = 1'b0;
  logic [15:0] last_wr = '0;

  vga_reg_writer dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .VSync      (VSync),
    .SrcAddr    (SrcAddr),
    .SrcReq     (SrcReq),
    .SrcAck     (SrcAck),
    .SrcData    (SrcData),
    .MemAddrOUT (MemAddrOUT),
    .MemDataOUT (MemDataOUT),
    .Write      (Write),
    .Busy       (Busy),
    .FrameDone  (FrameDone),
    .SrcErr     (SrcErr),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // register source: acks ack_dly[addr] cycles into the wait, or never if no_ack[addr]
  always @(negedge CLK) begin
    if (SrcReq) begin
      req_cnt = req_cnt + 1;
      if (!no_ack[SrcAddr] && (req_cnt == 2 + ack_dly[SrcAddr])) begin
        SrcAck  = 1'b1;
        SrcData = src_mem[SrcAddr];
      end else begin
        SrcAck  = 1'b0;
        SrcData = 8'($urandom);
      end
    end else begin
      req_cnt = 0;
      SrcAck  = 1'b0;
      SrcData = 8'($urandom);
    end
  end

  // bus monitor
  always @(negedge CLK) begin
    if (Write) got_q.push_back({MemAddrOUT, MemDataOUT});
    if (Write && wr_prev) wr_double++;
    if (wr_prev && !Write && RESET && ({MemAddrOUT, MemDataOUT} !== last_wr)) hold_err++;
    if (Write) last_wr = {MemAddrOUT, MemDataOUT};
    if (SrcReq && !req_prev) req_q.push_back(SrcAddr);
    if (SrcReq) req_cycles[SrcAddr]++;
    if (SrcErr && !err_prev) err_at = req_cycles[44];
    if (FrameDone) fd_cnt++;
    req_prev = SrcReq;
    err_prev = SrcErr;
    wr_prev  = Write;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // reference: what the display bank should receive for a given address and source byte
  function automatic logic [7:0] model_data(input logic [7:0] a, input logic [7:0] d);
    logic [3:0] hi;
    logic [3:0] lo;
`ifdef CRONO_INVERT_EN
    int tens;
    int units;
    tens  = int'(d[7:4]);
    units = int'(d[3:0]);
`endif
    hi = d[7:4];
    lo = d[3:0];
    if (a == 8'd50 || a == 8'd51) return {7'd0, d[0]};
`ifdef CRONO_INVERT_EN
    if (a == 8'd46 || a == 8'd47) begin
      hi = 4'(5 - tens);
      lo = 4'(9 - units);
    end else if (a == 8'd48) begin
      if (units > 3) begin
        hi = 4'(1 - tens);
        lo = 4'(13 - units);
      end else begin
        hi = 4'(2 - tens);
        lo = 4'(3 - units);
      end
    end
`endif
    return {hi, lo};
  endfunction

  function automatic logic [15:0] find_wr(input logic [7:0] a);
    logic [15:0] r;
    r = 16'hffff;
    foreach (got_q[i]) if (got_q[i][15:8] == a) r = got_q[i];
    return r;
  endfunction

  task automatic randomize_src(input int max_dly);
    foreach (src_mem[i]) src_mem[i] = 8'($urandom);
    foreach (ack_dly[i]) ack_dly[i] = $urandom_range(0, max_dly);
    foreach (no_ack[i]) no_ack[i] = 1'b0;
  endtask

  task automatic start_sweep();
    VSync = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    got_q.delete();
    req_q.delete();
    fd_cnt = 0;
    err_at = -1;
    foreach (req_cycles[i]) req_cycles[i] = 0;
    VSync = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge CLK);
      #1;
      if (fd_cnt > 0) begin
        n = i;
        break;
      end
    end
    repeat (2) @(negedge CLK);
    #1;
  endtask

  // scoreboard: expected request order and writes for a sweep of 40..last
  task automatic compare_sweep(input string tag, input int last);
    logic [7:0] exp_req [$];
    exp_q.delete();
    for (int a = 40; a <= last; a++) begin
      if (a == 43) continue;
      exp_req.push_back(8'(a));
      if (!no_ack[a]) exp_q.push_back({8'(a), model_data(8'(a), src_mem[a])});
    end
    check({tag, "_nwr"}, got_q.size(), exp_q.size());
    check({tag, "_nreq"}, req_q.size(), exp_req.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_wr"}, got_q.pop_front(), exp_q.pop_front());
    while (exp_req.size() > 0 && req_q.size() > 0)
      check({tag, "_req"}, req_q.pop_front(), exp_req.pop_front());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_srcreq"}, SrcReq, 0);
    check({tag, "_write"}, Write, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_framedone"}, FrameDone, 0);
    check({tag, "_srcerr"}, SrcErr, 0);
    check({tag, "_srcaddr"}, SrcAddr, 0);
    check({tag, "_memaddr"}, MemAddrOUT, 0);
    check({tag, "_memdata"}, MemDataOUT, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    int n;
    int nwr;
    bit ok;
    RESET = 1'b0;
    VSync = 1'b1;
    randomize_src(0);

    // reset holds everything idle, even across a VSync fall
    repeat (3) @(negedge CLK);
    #1;
    check_all_zero("rst");
    VSync = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_fall_busy", Busy, 0);
    VSync = 1'b1;
    @(negedge CLK);
    #1;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check("idle_busy", Busy, 0);

    // sweep A: 1-cycle acks, 0x37 at 41
    randomize_src(0);
    src_mem[41] = 8'h37;
`ifdef CRONO_INVERT_EN
    src_mem[46] = 8'h21;
    src_mem[48] = 8'h05;
`endif
    start_sweep();
    wait_done(1000, n);
    check("a_cycles", n, 45);
    check("a_wr41", find_wr(8'd41), {8'd41, 8'h37});
`ifdef CRONO_INVERT_EN
    check("a_wr48", find_wr(8'd48), {8'd48, 8'h18});
`endif
    check("a_no43", find_wr(8'd43), 16'hffff);
    check("a_fd_pulses", fd_cnt, 1);
    check("a_err", SrcErr, 0);
    check("a_busy_after", Busy, 0);
    compare_sweep("a", 51);

    // sweep B: address 44 never acked
    randomize_src(3);
    no_ack[44] = 1'b1;
    start_sweep();
    wait_done(1000, n);
    check("b_done", int'(n > 0), 1);
    check("b_err", SrcErr, 1);
    check("b_req44_cycles", req_cycles[44], 16);
    check("b_err_at", err_at, 16);
    check("b_no44", find_wr(8'd44), 16'hffff);
    compare_sweep("b", 51);
    no_ack[44] = 1'b0;

    // sweep C: VSync rises after the address-42 write
    randomize_src(2);
    start_sweep();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      #1;
      if (got_q.size() >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("c_reach42", ok, 1);
    @(negedge CLK);
    #1;
    VSync = 1'b1;
    @(negedge CLK);
    #1;
    check("c_abort_write", Write, 0);
    check("c_abort_srcreq", SrcReq, 0);
    check("c_abort_busy", Busy, 0);
    repeat (60) @(negedge CLK);
    #1;
    check("c_no_fd", fd_cnt, 0);
    compare_sweep("c", 42);
    start_sweep();
    wait_done(1000, n);
    check("c2_done", int'(n > 0), 1);
    compare_sweep("c2", 51);

    // sweep D: reset during a WRITE cycle
    randomize_src(1);
    start_sweep();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      #1;
      if (got_q.size() >= 2 && Write === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("d_reach_write", ok, 1);
    RESET = 1'b0;
    #1;
    check_all_zero("d_rst");
    nwr = got_q.size();
    repeat (2) @(negedge CLK);
    #1;
    RESET = 1'b1;
    repeat (20) @(negedge CLK);
    #1;
    check("d_stay_idle", Busy, 0);
    check("d_no_wr", got_q.size(), nwr);
    start_sweep();
    wait_done(1000, n);
    check("d2_done", int'(n > 0), 1);
    compare_sweep("d2", 51);

    // random sweeps with random latencies and an occasional dead address
    for (int k = 0; k < 3; k++) begin
      randomize_src(5);
      if ($urandom_range(0, 1) == 1) no_ack[$urandom_range(40, 51)] = 1'b1;
      start_sweep();
      wait_done(1000, n);
      check("r_done", int'(n > 0), 1);
      check("r_fd_pulses", fd_cnt, 1);
      compare_sweep("r", 51);
    end

    check("write_single_cycle", wr_double, 0);
    check("write_data_hold", hold_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
